pmem_arbiter: RTL and testbench

Sits between the split L1 caches (I-cache, D-cache) inside mp3 and the single physical memory port (pmem_*). Serialises 256-bit line reads and writebacks from both caches onto one pmem channel. Holds each transaction in registers for its full duration and returns read data with a one-cycle response pulse to the requester that owns the transaction.

---
 rtl/pmem_arbiter.sv | 155 +++++++++++++++
 tb/tb_pmem_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - serialises I-cache and D-cache line transfers onto one pmem port
//
// Purpose:
//   Arbitrates between the I-cache (line reads) and the D-cache (line reads and
//   writebacks) for a single physical memory channel. The winning request is
//   captured into registers and driven unchanged onto pmem_* until pmem_resp.
//   Completion is reported one cycle later as a single-cycle resp pulse to the
//   owner, together with the captured read line.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_read, i_address               I-cache line read request (held until i_resp)
//   i_rdata, i_resp                 I-cache returned line and completion pulse
//   d_read, d_write, d_address,     D-cache read / writeback request (held until
//   d_wdata                         d_resp), line address and writeback data
//   d_rdata, d_resp                 D-cache returned line and completion pulse
//   pmem_read, pmem_write,          physical memory strobes, address and write
//   pmem_address, pmem_wdata        data (all registered)
//   pmem_rdata, pmem_resp           physical memory read data and completion
//
// Build option:
//   ARB_RR_EN  defined   -> round-robin between I and D when both are pending
//              undefined -> fixed priority, D-cache wins

module pmem_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t r_state;

  logic w_i_req;
  logic w_d_req;
  logic w_grant_d;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

`ifdef ARB_RR_EN
  // Set when the most recent grant went to the D-cache.
  logic r_last_grant_d;

  // On contention the requester that was not granted last wins.
  assign w_grant_d = w_d_req & (~w_i_req | ~r_last_grant_d);
`else
  assign w_grant_d = w_d_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      i_resp       <= 1'b0;
      d_resp       <= 1'b0;
`ifdef ARB_RR_EN
      r_last_grant_d <= 1'b0;
`endif
    end else begin
      // Response pulses last exactly one cycle (the DONE cycle).
      i_resp <= 1'b0;
      d_resp <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_i_req || w_d_req) begin
            if (w_grant_d) begin
              r_state      <= BUSY_D;
              pmem_address <= d_address;
              pmem_wdata   <= d_wdata;
              // A simultaneous read+write from the D-cache is taken as a write.
              pmem_write   <= d_write;
              pmem_read    <= ~d_write;
            end else begin
              r_state      <= BUSY_I;
              pmem_address <= i_address;
              pmem_write   <= 1'b0;
              pmem_read    <= 1'b1;
            end
`ifdef ARB_RR_EN
            r_last_grant_d <= w_grant_d;
`endif
          end
        end

        BUSY_I: begin
          if (pmem_resp) begin
            i_rdata   <= pmem_rdata;
            i_resp    <= 1'b1;
            pmem_read <= 1'b0;
            r_state   <= DONE;
          end
        end

        BUSY_D: begin
          if (pmem_resp) begin
            // The held write strobe tells us which op is in flight; writebacks
            // leave the previously returned line untouched.
            if (!pmem_write) begin
              d_rdata <= pmem_rdata;
            end
            d_resp     <= 1'b1;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            r_state    <= DONE;
          end
        end

        // One dead cycle so the served requester can drop its request before
        // the next arbitration decision.
        DONE: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // The D-cache must never request a read and a writeback at the same time.
  assert property (@(posedge clk) disable iff (!rst_n) !(d_read && d_write));

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb/tb_pmem_arbiter.sv - self-checking bench for pmem_arbiter

module tb_pmem_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk;
  logic          rst_n;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  pmem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected DUT outputs for the current cycle.
  logic          e_pread, e_pwrite, e_iresp, e_dresp;
  logic [AW-1:0] e_addr;
  logic [LW-1:0] e_wdata, e_irdata, e_drdata;
  // Transaction-level reference state.
  int            m_busy;   // 0 none, 1 I-cache, 2 D-cache transaction in flight
  int            m_hold;   // edges to skip before the next grant is allowed
  logic          m_write;
`ifdef ARB_RR_EN
  logic          m_last_d;
`endif
  int            dut_resp_cnt = 0;
  int            model_done_cnt = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    e_pread = 0; e_pwrite = 0; e_iresp = 0; e_dresp = 0;
    e_addr = '0; e_wdata = '0; e_irdata = '0; e_drdata = '0;
    m_busy = 0; m_hold = 0; m_write = 0;
`ifdef ARB_RR_EN
    m_last_d = 0;
`endif
  endtask

  // Advance the reference by one clock edge using the inputs now being driven.
  task automatic model_step();
    logic ir, dr, gd;
    if (!rst_n) begin
      model_reset();
      return;
    end
    e_iresp = 0;
    e_dresp = 0;
    if (m_busy != 0) begin
      if (pmem_resp) begin
        if (m_busy == 1) begin
          e_irdata = pmem_rdata;
          e_iresp  = 1;
        end else begin
          if (!m_write) e_drdata = pmem_rdata;
          e_dresp = 1;
        end
        model_done_cnt++;
        m_busy = 0; m_hold = 1; e_pread = 0; e_pwrite = 0;
      end
    end else if (m_hold > 0) begin
      m_hold--;
    end else begin
      ir = i_read;
      dr = d_read | d_write;
      if (ir || dr) begin
`ifdef ARB_RR_EN
        gd = dr && (!ir || !m_last_d);
        m_last_d = gd;
`else
        gd = dr;
`endif
        if (gd) begin
          m_busy = 2; m_write = d_write; e_addr = d_address; e_wdata = d_wdata;
        end else begin
          m_busy = 1; m_write = 0; e_addr = i_address;
        end
        e_pwrite = m_write;
        e_pread  = !m_write;
      end
    end
  endtask

  task automatic compare();
    chk("pmem_read", LW'(pmem_read), LW'(e_pread));
    chk("pmem_write", LW'(pmem_write), LW'(e_pwrite));
    if (e_pread || e_pwrite) chk("pmem_address", LW'(pmem_address), LW'(e_addr));
    if (e_pwrite) chk("pmem_wdata", pmem_wdata, e_wdata);
    chk("i_resp", LW'(i_resp), LW'(e_iresp));
    chk("d_resp", LW'(d_resp), LW'(e_dresp));
    chk("i_rdata", i_rdata, e_irdata);
    chk("d_rdata", d_rdata, e_drdata);
    chk("resp_exclusive", LW'(i_resp & d_resp), LW'(0));
    if (i_resp || d_resp) dut_resp_cnt++;
  endtask

  task automatic tick_begin();
    @(negedge clk);
    compare();
    pmem_resp = 1'b0;
  endtask

  task automatic tick_end();
    model_step();
  endtask

  task automatic tick();
    tick_begin();
    tick_end();
  endtask

  // Random requesters and memory; requesters drop on their resp.
  task automatic rand_drive(input bit allow_new);
    if (e_iresp) i_read = 0;
    else if (allow_new && !i_read && $urandom_range(3) == 0) i_read = 1;
    if (i_read) i_address = $urandom & ~32'h1f;
    if (e_dresp) begin
      d_read = 0; d_write = 0;
    end else if (allow_new && !d_read && !d_write && $urandom_range(3) == 0) begin
      if ($urandom_range(1) == 1) d_write = 1;
      else d_read = 1;
    end
    if (d_read || d_write) begin
      d_address = $urandom & ~32'h1f;
      d_wdata   = rnd_line();
    end
    pmem_rdata = rnd_line();
    if (e_pread || e_pwrite) pmem_resp = ($urandom_range(2) == 0);
    else pmem_resp = ($urandom_range(7) == 0);
  endtask

  task automatic drain(input string name);
    bit idle = 0;
    for (int c = 0; c < 300 && !idle; c++) begin
      tick_begin();
      rand_drive(1'b0);
      tick_end();
      idle = (m_busy == 0) && (m_hold == 0) && !i_read && !d_read && !d_write && !e_iresp && !e_dresp;
    end
    chk({name, "_drained"}, LW'(idle), LW'(1));
  endtask

  // Memory answers after `lat` strobe cycles; requester drops on its resp.
  task automatic finish_txn(input bit is_d, input int lat, input string name);
    int  n = 0;
    bit  seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      tick_begin();
      if ((is_d ? d_resp : i_resp) === 1'b1) begin
        seen = 1;
        if (is_d) begin d_read = 0; d_write = 0; end
        else i_read = 0;
      end else if (pmem_read || pmem_write) begin
        n++;
        if (n >= lat) begin
          pmem_resp  = 1'b1;
          pmem_rdata = rnd_line();
        end
      end
      tick_end();
    end
    chk({name, "_resp_seen"}, LW'(seen), LW'(1));
  endtask

  logic [AW-1:0] dut_order[$];
  logic [AW-1:0] exp_order[4];
  logic          prev_strobe;
  logic [AW-1:0] first_addr, second_addr;
  bit            first_is_d;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 0; i_read = 0; i_address = '0; d_read = 0; d_write = 0;
    d_address = '0; d_wdata = '0; pmem_rdata = '0; pmem_resp = 0;
    model_reset();

    // Reset state
    tick_begin();
    chk("rst_pmem_address", LW'(pmem_address), LW'(0));
    chk("rst_pmem_wdata", pmem_wdata, LW'(0));
    tick_end();
    tick_begin(); rst_n = 1; tick_end();

    // I-only read, memory answers in the third strobe cycle
    tick_begin(); i_read = 1; i_address = 32'h60; tick_end();
    tick_begin();
    chk("t1_pmem_read", LW'(pmem_read), LW'(1));
    chk("t1_pmem_address", LW'(pmem_address), LW'(32'h60));
    tick_end();
    tick();
    tick_begin(); pmem_resp = 1; pmem_rdata = {32{8'hAA}}; tick_end();
    tick_begin();
    chk("t1_i_resp", LW'(i_resp), LW'(1));
    chk("t1_i_rdata", i_rdata, {32{8'hAA}});
    chk("t1_d_resp", LW'(d_resp), LW'(0));
    chk("t1_strobe_drop", LW'(pmem_read), LW'(0));
    i_read = 0;
    tick_end();
    tick_begin(); chk("t1_i_resp_single", LW'(i_resp), LW'(0)); tick_end();

    // D writeback
    tick_begin(); d_write = 1; d_address = 32'h100; d_wdata = {64{4'h5}}; tick_end();
    tick_begin();
    chk("t2_pmem_write", LW'(pmem_write), LW'(1));
    chk("t2_pmem_read", LW'(pmem_read), LW'(0));
    chk("t2_pmem_wdata", pmem_wdata, {64{4'h5}});
    chk("t2_pmem_address", LW'(pmem_address), LW'(32'h100));
    tick_end();
    finish_txn(1'b1, 2, "t2");
    chk("t2_d_rdata_kept", d_rdata, LW'(0));
    chk("t2_i_rdata_kept", i_rdata, {32{8'hAA}});

    // Simultaneous reads; last grant so far was D
`ifdef ARB_RR_EN
    first_is_d = 0; first_addr = 32'h40; second_addr = 32'h80;
`else
    first_is_d = 1; first_addr = 32'h80; second_addr = 32'h40;
`endif
    tick_begin(); i_read = 1; d_read = 1; i_address = 32'h40; d_address = 32'h80; tick_end();
    tick_begin();
    chk("t3_first_addr", LW'(pmem_address), LW'(first_addr));
    pmem_resp = 1; pmem_rdata = {8{32'h1234_5678}};
    tick_end();
    tick_begin();
    chk("t3_first_resp", LW'(first_is_d ? d_resp : i_resp), LW'(1));
    if (first_is_d) d_read = 0; else i_read = 0;
    tick_end();
    tick_begin(); chk("t3_gap", LW'(pmem_read), LW'(0)); tick_end();
    tick_begin();
    chk("t3_second_strobe", LW'(pmem_read), LW'(1));
    chk("t3_second_addr", LW'(pmem_address), LW'(second_addr));
    pmem_resp = 1; pmem_rdata = {8{32'h9abc_def0}};
    tick_end();
    tick_begin();
    chk("t3_second_resp", LW'(first_is_d ? i_resp : d_resp), LW'(1));
    chk("t3_first_rdata", first_is_d ? d_rdata : i_rdata, {8{32'h1234_5678}});
    chk("t3_second_rdata", first_is_d ? i_rdata : d_rdata, {8{32'h9abc_def0}});
    i_read = 0; d_read = 0;
    tick_end();

    // Asynchronous reset during a D transaction
    tick_begin(); d_read = 1; d_address = 32'h180; tick_end();
    tick_begin();
    #2 rst_n = 0;
    #1;
    chk("t4_rst_pread", LW'(pmem_read), LW'(0));
    chk("t4_rst_pwrite", LW'(pmem_write), LW'(0));
    chk("t4_rst_dresp", LW'(d_resp), LW'(0));
    chk("t4_rst_iresp", LW'(i_resp), LW'(0));
    chk("t4_rst_addr", LW'(pmem_address), LW'(0));
    chk("t4_rst_drdata", d_rdata, LW'(0));
    d_read = 0;
    tick_end();
    tick_begin(); rst_n = 1; pmem_resp = 1; tick_end();
    tick_begin();
    chk("t4_stray_no_dresp", LW'(d_resp), LW'(0));
    chk("t4_stray_no_strobe", LW'(pmem_read), LW'(0));
    i_read = 1; i_address = 32'h20;
    tick_end();
    finish_txn(1'b0, 1, "t4");

    // Requester address churn while busy
    tick_begin(); d_read = 1; d_address = 32'h200; tick_end();
    for (int c = 0; c < 4; c++) begin
      tick_begin();
      chk("t5_addr_held", LW'(pmem_address), LW'(32'h200));
      chk("t5_strobe", LW'(pmem_read), LW'(1));
      d_address = 32'h300;
      tick_end();
    end
    finish_txn(1'b1, 1, "t5");

    // Both requesters held for four grants, starting from reset
    tick_begin(); rst_n = 0; tick_end();
    tick_begin(); rst_n = 1; tick_end();
`ifdef ARB_RR_EN
    exp_order[0] = 32'h80; exp_order[1] = 32'h40; exp_order[2] = 32'h80; exp_order[3] = 32'h40;
`else
    exp_order[0] = 32'h80; exp_order[1] = 32'h80; exp_order[2] = 32'h80; exp_order[3] = 32'h80;
`endif
    prev_strobe = 0;
    tick_begin(); i_read = 1; d_read = 1; i_address = 32'h40; d_address = 32'h80; tick_end();
    for (int c = 0; c < 200 && dut_order.size() < 4; c++) begin
      tick_begin();
      if (pmem_read && !prev_strobe) dut_order.push_back(pmem_address);
      prev_strobe = pmem_read;
      pmem_resp = pmem_read;
      tick_end();
    end
    chk("t6_grant_count", LW'(dut_order.size()), LW'(4));
    for (int k = 0; k < 4 && k < dut_order.size(); k++)
      chk($sformatf("t6_grant_%0d", k), LW'(dut_order[k]), LW'(exp_order[k]));
    drain("t6");

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick_begin();
      rand_drive(1'b1);
      tick_end();
    end
    drain("rand");
    chk("resp_total", LW'(dut_resp_cnt), LW'(model_done_cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
